// File: rtl/idma_desc64_credit_counter.sv
// Multi-channel credit counter for the 64-bit descriptor frontend.
// Each channel applies the net change (inc - dec) in a single update.
// Underflow clamps at zero. Overflow either wraps or saturates.
// Sticky error flags and a threshold compare are kept per channel.

module idma_desc64_credit_counter_chan #(
    parameter int unsigned CounterWidth     = 4,
    parameter int unsigned StepWidth        = 2,
    parameter bit          SaturateOverflow = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    err_clear_i,
    input  logic                    increment_i,
    input  logic [StepWidth-1:0]    inc_amount_i,
    input  logic                    decrement_i,
    input  logic [StepWidth-1:0]    dec_amount_i,
    input  logic [CounterWidth-1:0] threshold_i,
    output logic [CounterWidth-1:0] count_o,
    output logic                    greater_than_zero_o,
    output logic                    at_threshold_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);
    // Two guard bits: one for carry above max, one as the sign bit.
    localparam int unsigned RawWidth = CounterWidth + StepWidth + 2;

    logic [CounterWidth-1:0] counter_q, counter_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;
    logic [RawWidth-1:0]     inc_ext, dec_ext, raw;
    logic                    raw_neg, raw_big;
    logic                    ovf_event, udf_event;

    // Zero-extended gated step amounts and the signed raw sum.
    always_comb begin
        inc_ext = '0;
        dec_ext = '0;
        if (increment_i) inc_ext = RawWidth'(inc_amount_i);
        if (decrement_i) dec_ext = RawWidth'(dec_amount_i);
        raw     = RawWidth'(counter_q) + inc_ext - dec_ext;
        raw_neg = raw[RawWidth-1];
        raw_big = |raw[RawWidth-2:CounterWidth];
    end

    // Next counter value; clear beats any request and suppresses events.
    always_comb begin
        counter_d = raw[CounterWidth-1:0];
        ovf_event = 1'b0;
        udf_event = 1'b0;
        if (clear_i) begin
            counter_d = '0;
        end else if (raw_neg) begin
            counter_d = '0;
            udf_event = 1'b1;
        end else if (raw_big) begin
            ovf_event = 1'b1;
            if (SaturateOverflow) counter_d = '1;
        end
    end

    // Sticky flags: a same-cycle event wins over err_clear_i.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clear_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_event) overflow_d  = 1'b1;
        if (udf_event) underflow_d = 1'b1;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            counter_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Status outputs depend only on registered state and threshold_i.
    always_comb begin
        count_o             = counter_q;
        greater_than_zero_o = (counter_q != '0);
        at_threshold_o      = (counter_q >= threshold_i);
        overflow_o          = overflow_q;
        underflow_o         = underflow_q;
    end
endmodule

module idma_desc64_credit_counter #(
    parameter int unsigned NumChannels      = 2,
    parameter int unsigned CounterWidth     = 4,
    parameter int unsigned StepWidth        = 2,
    parameter bit          SaturateOverflow = 1'b0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumChannels-1:0]              clear_i,
    input  logic [NumChannels-1:0]              err_clear_i,
    input  logic [NumChannels-1:0]              increment_i,
    input  logic [NumChannels*StepWidth-1:0]    inc_amount_i,
    input  logic [NumChannels-1:0]              decrement_i,
    input  logic [NumChannels*StepWidth-1:0]    dec_amount_i,
    input  logic [NumChannels*CounterWidth-1:0] threshold_i,
    output logic [NumChannels*CounterWidth-1:0] count_o,
    output logic [NumChannels-1:0]              greater_than_zero_o,
    output logic [NumChannels-1:0]              at_threshold_o,
    output logic [NumChannels-1:0]              overflow_o,
    output logic [NumChannels-1:0]              underflow_o
);
    // One fully independent counter per channel.
    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        idma_desc64_credit_counter_chan #(
            .CounterWidth     (CounterWidth),
            .StepWidth        (StepWidth),
            .SaturateOverflow (SaturateOverflow)
        ) i_chan (
            .clk_i               (clk_i),
            .rst_ni              (rst_ni),
            .clear_i             (clear_i[c]),
            .err_clear_i         (err_clear_i[c]),
            .increment_i         (increment_i[c]),
            .inc_amount_i        (inc_amount_i[c*StepWidth +: StepWidth]),
            .decrement_i         (decrement_i[c]),
            .dec_amount_i        (dec_amount_i[c*StepWidth +: StepWidth]),
            .threshold_i         (threshold_i[c*CounterWidth +: CounterWidth]),
            .count_o             (count_o[c*CounterWidth +: CounterWidth]),
            .greater_than_zero_o (greater_than_zero_o[c]),
            .at_threshold_o      (at_threshold_o[c]),
            .overflow_o          (overflow_o[c]),
            .underflow_o         (underflow_o[c])
        );
    end
endmodule

// File: tb/tb_idma_desc64_credit_counter.sv
// Bench for idma_desc64_credit_counter: a wrapping and a saturating instance
// share the same stimulus; an arithmetic model is compared every negedge,
// and literal expectations pin key points of the directed sequence.

module tb_idma_desc64_credit_counter;
    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int SW  = 2;
    localparam int MAXV = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH-1:0]    clr = '0, eclr = '0, inc = '0, dec = '0;
    logic [NCH*SW-1:0] ia = '0, da = '0;
    logic [NCH*CW-1:0] thr = '0;

    // index 0: wrapping instance, index 1: saturating instance
    logic [NCH*CW-1:0] cnt_o [2];
    logic [NCH-1:0]    gtz_o [2];
    logic [NCH-1:0]    ath_o [2];
    logic [NCH-1:0]    ovf_o [2];
    logic [NCH-1:0]    udf_o [2];

    int vectors = 0;
    int miscompares = 0;

    // model state: [instance][channel]
    int m_cnt [2][NCH] = '{default: 0};
    int m_ovf [2][NCH] = '{default: 0};
    int m_udf [2][NCH] = '{default: 0};

    always #5 clk = ~clk;

    idma_desc64_credit_counter #(.NumChannels(NCH), .CounterWidth(CW), .StepWidth(SW),
                                 .SaturateOverflow(1'b0)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .err_clear_i(eclr),
        .increment_i(inc), .inc_amount_i(ia), .decrement_i(dec), .dec_amount_i(da),
        .threshold_i(thr), .count_o(cnt_o[0]), .greater_than_zero_o(gtz_o[0]),
        .at_threshold_o(ath_o[0]), .overflow_o(ovf_o[0]), .underflow_o(udf_o[0]));

    idma_desc64_credit_counter #(.NumChannels(NCH), .CounterWidth(CW), .StepWidth(SW),
                                 .SaturateOverflow(1'b1)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .err_clear_i(eclr),
        .increment_i(inc), .inc_amount_i(ia), .decrement_i(dec), .dec_amount_i(da),
        .threshold_i(thr), .count_o(cnt_o[1]), .greater_than_zero_o(gtz_o[1]),
        .at_threshold_o(ath_o[1]), .overflow_o(ovf_o[1]), .underflow_o(udf_o[1]));

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: plain integer arithmetic on the counting rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < NCH; c++) begin
                    m_cnt[d][c] = 0; m_ovf[d][c] = 0; m_udf[d][c] = 0;
                end
        end else begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < NCH; c++) begin
                    int r, ev_o, ev_u, a, b;
                    a = inc[c] ? int'(ia[c*SW +: SW]) : 0;
                    b = dec[c] ? int'(da[c*SW +: SW]) : 0;
                    r = m_cnt[d][c] + a - b;
                    ev_o = 0; ev_u = 0;
                    if (clr[c]) m_cnt[d][c] = 0;
                    else if (r < 0) begin m_cnt[d][c] = 0; ev_u = 1; end
                    else if (r > MAXV) begin
                        m_cnt[d][c] = (d == 1) ? MAXV : r % (MAXV + 1);
                        ev_o = 1;
                    end else m_cnt[d][c] = r;
                    if (ev_o) m_ovf[d][c] = 1; else if (eclr[c]) m_ovf[d][c] = 0;
                    if (ev_u) m_udf[d][c] = 1; else if (eclr[c]) m_udf[d][c] = 0;
                end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
                int tv;
                tv = int'(thr[c*CW +: CW]);
                chk($sformatf("cnt d%0d c%0d", d, c), int'(cnt_o[d][c*CW +: CW]), m_cnt[d][c]);
                chk($sformatf("gtz d%0d c%0d", d, c), int'(gtz_o[d][c]), int'(m_cnt[d][c] != 0));
                chk($sformatf("ath d%0d c%0d", d, c), int'(ath_o[d][c]), int'(m_cnt[d][c] >= tv));
                chk($sformatf("ovf d%0d c%0d", d, c), int'(ovf_o[d][c]), m_ovf[d][c]);
                chk($sformatf("udf d%0d c%0d", d, c), int'(udf_o[d][c]), m_udf[d][c]);
            end
    end

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic cyc(input logic [1:0] c_cl, input logic [1:0] c_ecl,
                       input logic [1:0] c_inc, input logic [3:0] c_ia,
                       input logic [1:0] c_dec, input logic [3:0] c_da);
        clr = c_cl; eclr = c_ecl; inc = c_inc; ia = c_ia; dec = c_dec; da = c_da;
        @(posedge clk); #1;
        clr = '0; eclr = '0; inc = '0; ia = '0; dec = '0; da = '0;
    endtask

    // Channel-0 shorthands.
    task automatic inc0(input int n);
        cyc(2'b00, 2'b00, 2'b01, 4'(n), 2'b00, 4'd0);
    endtask
    task automatic dec0(input int n, input logic ec);
        cyc(2'b00, {1'b0, ec}, 2'b00, 4'd0, 2'b01, 4'(n));
    endtask

    task automatic lit0(input string name, input int cw, input int cs,
                        input int ov, input int ud);
        chk({name, " wrap cnt"}, int'(cnt_o[0][CW-1:0]), cw);
        chk({name, " sat cnt"},  int'(cnt_o[1][CW-1:0]), cs);
        chk({name, " wrap ovf"}, int'(ovf_o[0][0]), ov);
        chk({name, " sat ovf"},  int'(ovf_o[1][0]), ov);
        chk({name, " wrap udf"}, int'(udf_o[0][0]), ud);
        chk({name, " sat udf"},  int'(udf_o[1][0]), ud);
    endtask

    initial begin
        thr = {4'd5, 4'd0};
        #11;
        // reset state
        lit0("reset", 0, 0, 0, 0);
        chk("reset ath c0", int'(ath_o[0][0]), 1);
        chk("reset ath c1", int'(ath_o[0][1]), 0);
        chk("reset gtz", int'(gtz_o[0]), 0);
        rst_n = 1'b1;

        // two increments of 3 on channel 0
        inc0(3); inc0(3);
        lit0("inc6", 6, 6, 0, 0);
        chk("inc6 gtz c0", int'(gtz_o[0][0]), 1);
        chk("inc6 c1 cnt", int'(cnt_o[0][2*CW-1:CW]), 0);

        // underflow, err_clear, err_clear coincident with underflow
        cyc(2'b01, 2'b00, 2'b00, 4'd0, 2'b00, 4'd0);
        inc0(2);
        dec0(3, 1'b0);
        lit0("udf", 0, 0, 0, 1);
        cyc(2'b00, 2'b01, 2'b00, 4'd0, 2'b00, 4'd0);
        lit0("udf clr", 0, 0, 0, 0);
        dec0(1, 1'b0);
        dec0(1, 1'b1);
        lit0("udf vs eclr", 0, 0, 0, 1);

        // overflow: 14 + 3
        cyc(2'b01, 2'b01, 2'b00, 4'd0, 2'b00, 4'd0);
        inc0(3); inc0(3); inc0(3); inc0(3); inc0(2);
        lit0("pre ovf", 14, 14, 0, 0);
        inc0(3);
        lit0("ovf", 1, 15, 1, 0);

        // net update and equal amounts
        cyc(2'b01, 2'b01, 2'b00, 4'd0, 2'b00, 4'd0);
        inc0(3); inc0(2);
        cyc(2'b00, 2'b00, 2'b01, 4'd3, 2'b01, 4'd2);
        lit0("net", 6, 6, 0, 0);
        dec0(1, 1'b0);
        cyc(2'b00, 2'b00, 2'b01, 4'd2, 2'b01, 4'd2);
        lit0("equal", 5, 5, 0, 0);
        cyc(2'b00, 2'b00, 2'b01, 4'd0, 2'b00, 4'd0);
        lit0("zero amt", 5, 5, 0, 0);

        // clear vs increment; flags untouched by clear
        cyc(2'b01, 2'b00, 2'b00, 4'd0, 2'b00, 4'd0);
        dec0(1, 1'b0);
        inc0(3); inc0(3); inc0(3);
        lit0("nine", 9, 9, 0, 1);
        cyc(2'b01, 2'b00, 2'b01, 4'd3, 2'b00, 4'd0);
        lit0("clr+inc", 0, 0, 0, 1);

        // threshold crossing
        thr = {4'd5, 4'd4};
        inc0(2);
        chk("thr at 2", int'(ath_o[0][0]), 0);
        inc0(2);
        chk("thr at 4", int'(ath_o[0][0]), 1);
        chk("thr at 4 sat", int'(ath_o[1][0]), 1);

        // channel 1 activity while channel 0 idles
        cyc(2'b00, 2'b00, 2'b10, 4'b1100, 2'b00, 4'd0);
        cyc(2'b00, 2'b00, 2'b10, 4'b1000, 2'b10, 4'b0100);
        chk("c1 cnt", int'(cnt_o[0][2*CW-1:CW]), 4);
        chk("c0 hold", int'(cnt_o[0][CW-1:0]), 4);

        // count 7 with overflow set, then asynchronous reset mid-cycle
        cyc(2'b01, 2'b01, 2'b00, 4'd0, 2'b00, 4'd0);
        for (int i = 0; i < 6; i++) inc0(3);
        lit0("ovf again", 2, 15, 1, 0);
        cyc(2'b01, 2'b00, 2'b00, 4'd0, 2'b00, 4'd0);
        inc0(3); inc0(3); inc0(1);
        lit0("seven", 7, 7, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        lit0("async rst", 0, 0, 0, 0);
        chk("async rst c1", int'(cnt_o[0][2*CW-1:CW]), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        inc0(1);
        lit0("post rst", 1, 1, 0, 0);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/idma_desc64_credit_counter.md
# idma_desc64_credit_counter

Multi-channel credit counter shared between a producer domain and a consumer domain of the 64-bit descriptor frontend. Each channel holds an independent counter. The producer adds a variable number of credits per cycle and the consumer removes a variable number per cycle, with the net change applied in a single update. Overflow handling (wrap or saturate) is selectable per instance. Underflow always saturates at zero. Sticky error flags and threshold comparison let the descriptor engine throttle prefetch without a full FIFO.

## Interface
- NumChannels, default 2: number of independent counters.
- CounterWidth, default 4: bits per counter; max value 2^CounterWidth-1.
- StepWidth, default 2: bits per increment/decrement amount.
- SaturateOverflow, default 1'b0: 0 = counter wraps modulo 2^CounterWidth on overflow; 1 = counter saturates at max.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  NumChannels  per-channel synchronous clear of the counter value.
- err_clear_i  in  NumChannels  per-channel synchronous clear of the sticky error flags.
- increment_i  in  NumChannels  per-channel increment request.
- inc_amount_i  in  NumChannels x StepWidth  credits added when increment_i is set.
- decrement_i  in  NumChannels  per-channel decrement request.
- dec_amount_i  in  NumChannels x StepWidth  credits removed when decrement_i is set.
- threshold_i  in  NumChannels x CounterWidth  per-channel comparison level.
- count_o  out  NumChannels x CounterWidth  current counter value (counter_q).
- greater_than_zero_o  out  NumChannels  counter_q != 0.
- at_threshold_o  out  NumChannels  counter_q >= threshold_i (unsigned).
- overflow_o  out  NumChannels  sticky overflow flag.
- underflow_o  out  NumChannels  sticky underflow flag.

## Operation
- Channels are fully independent. No cross-channel interaction.
- Per channel, inc = increment_i ? inc_amount_i : 0 and dec = decrement_i ? dec_amount_i : 0. Both are zero-extended.
- The raw result is computed as a signed value of CounterWidth+StepWidth+2 bits: raw = counter_q + inc - dec.
- raw < 0: counter_d = 0 and the underflow event fires. Partial decrements are absorbed; credits are never borrowed.
- raw > max:
  - SaturateOverflow=0: counter_d = raw mod 2^CounterWidth.
  - SaturateOverflow=1: counter_d = max.
  - The overflow event fires in both modes.
- 0 <= raw <= max: counter_d = raw. No event fires.
- If inc and dec are both asserted with equal amounts, the counter is held and no event fires.
- An asserted request with amount 0 is a no-op and fires no event.
- clear_i has priority over increment and decrement: counter_d = 0, and no overflow/underflow event fires in that cycle.
- Sticky flags:
  - A flag sets on its event and holds until err_clear_i.
  - If err_clear_i and an event occur in the same cycle, the event wins and the flag stays or becomes 1.
  - clear_i does not affect the flags.
- at_threshold_o and greater_than_zero_o are combinational from counter_q (and threshold_i). They are glitch-free with respect to the inc/dec inputs.

## Timing
- Reset (rst_ni low, asynchronous): all counters = 0 and all flags = 0. Outputs immediately read count_o=0, greater_than_zero_o=0, overflow_o=0, underflow_o=0. at_threshold_o reads 1 only where threshold_i=0.
- Reset mid-operation discards pending requests. The first update after rst_ni deasserts occurs on the next rising edge.
- One-cycle latency: inputs sampled at edge N are visible on count_o and all flags after edge N.
- No handshakes. Requests are single-cycle pulses or level-held; each cycle held counts once.
- threshold_i may change any cycle, and at_threshold_o follows combinationally.

## Test plan
- Reset, then increment channel 0 by 3 for two cycles -> count_o[0]=6, greater_than_zero_o[0]=1, channel 1 stays 0, no flags.
- count=2, decrement by 3 -> count=0, underflow_o=1. Next cycle err_clear_i -> underflow_o=0. err_clear_i coincident with another underflow -> underflow_o stays 1.
- CounterWidth=4, count=14, increment by 3 -> count=1 with SaturateOverflow=0, count=15 with SaturateOverflow=1, overflow_o=1 in both modes.
- count=5, same-cycle increment 3 and decrement 2 -> count=6. Increment 2 with decrement 2 -> count stays 5, no flags.
- count=9, clear_i with increment 3 in the same cycle -> count=0, flags unchanged. Then threshold_i=4 with increments of 2 -> at_threshold_o rises exactly when count reaches 4.
- Assert rst_ni low asynchronously mid-cycle with count=7 and overflow_o=1 -> count_o=0 and overflow_o=0 before the next clock edge.
